// File: rtl/div_operand_sequencer.sv
// Sign-handling wrapper around the unsigned sequential divide core: takes signed
// operands, launches the core on magnitudes, and returns a sign-corrected result.
module div_operand_sequencer #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] div_a,
   output logic [W-1:0] div_b,
   output logic         div_bgn,
   input  logic         div_stop,
   input  logic [W-1:0] div_obus,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         dz,
   output logic         ovf
);

   localparam logic [W-1:0] ZERO_C = {W{1'b0}};
   localparam logic [W-1:0] ONES_C = {W{1'b1}};
   localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] MIN_C  = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      WAIT   = 3'd2,
      CAP_R  = 3'd3,
      CAP_Q  = 3'd4,
      FIX    = 3'd5,
      DONE   = 3'd6
   } state_t;

   state_t       state_r;
   state_t       next_s;
   logic         accept_s;
   logic         div_zero_s;
   logic         ovf_case_s;
   logic         wait_armed_r;
   logic         sa_r;
   logic         sb_r;
   logic [W-1:0] q_mag_r;
   logic [W-1:0] r_mag_r;

   function automatic logic [W-1:0] neg_f(input logic [W-1:0] v);
      neg_f = ~v + ONE_C;
   endfunction

   // The most-negative value negates to itself, which is its correct unsigned magnitude.
   function automatic logic [W-1:0] mag_f(input logic [W-1:0] v);
      mag_f = v[W-1] ? neg_f(v) : v;
   endfunction

   assign div_zero_s = (divisor == ZERO_C);
   assign ovf_case_s = (dividend == MIN_C) && (divisor == ONES_C);

   // Next-state decode for the operand/result sequencing.
   always_comb begin
      next_s   = state_r;
      accept_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept_s = 1'b1;
               if (div_zero_s || ovf_case_s) begin
                  next_s = FIX;
               end else begin
                  next_s = LAUNCH;
               end
            end else begin
               next_s = IDLE;
            end
         end
         LAUNCH: next_s = WAIT;
         WAIT: begin
            // A stop still high from the previous op is not trusted until the core has seen bgn.
            if (div_stop && wait_armed_r) begin
               next_s = CAP_Q;
            end else begin
               next_s = WAIT;
            end
         end
         CAP_Q: next_s = FIX;
         FIX:   next_s = DONE;
         DONE: begin
            if (out_ready) begin
               next_s = IDLE;
            end else begin
               next_s = DONE;
            end
         end
         default: next_s = IDLE;
      endcase
   end

   // State register and state-derived handshake outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r      <= IDLE;
         in_ready     <= 1'b0;
         div_bgn      <= 1'b0;
         out_valid    <= 1'b0;
         wait_armed_r <= 1'b0;
      end else begin
         state_r      <= next_s;
         in_ready     <= (next_s == IDLE);
         div_bgn      <= (next_s == LAUNCH);
         out_valid    <= (next_s == DONE);
         wait_armed_r <= (state_r == WAIT);
      end
   end

   // Operand capture, core result capture and sign correction.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sa_r      <= 1'b0;
         sb_r      <= 1'b0;
         q_mag_r   <= ZERO_C;
         r_mag_r   <= ZERO_C;
         div_a     <= ZERO_C;
         div_b     <= ZERO_C;
         quotient  <= ZERO_C;
         remainder <= ZERO_C;
         dz        <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (accept_s) begin
            sa_r <= dividend[W-1];
            sb_r <= divisor[W-1];
            dz   <= div_zero_s;
            ovf  <= ovf_case_s;
            // Special cases preload their final values; FIX passes them through untouched.
            if (div_zero_s) begin
               q_mag_r <= ONES_C;
               r_mag_r <= dividend;
            end else if (ovf_case_s) begin
               q_mag_r <= MIN_C;
               r_mag_r <= ZERO_C;
            end else begin
               div_a <= mag_f(dividend);
               div_b <= mag_f(divisor);
            end
         end
         if ((state_r == WAIT) && (next_s == CAP_Q)) begin
            r_mag_r <= div_obus;
         end
         if (state_r == CAP_Q) begin
            q_mag_r <= div_obus;
         end
         if (state_r == FIX) begin
            if (dz || ovf) begin
               quotient  <= q_mag_r;
               remainder <= r_mag_r;
            end else begin
               quotient  <= (sa_r ^ sb_r) ? neg_f(q_mag_r) : q_mag_r;
               remainder <= sa_r ? neg_f(r_mag_r) : r_mag_r;
            end
         end
         if ((state_r == DONE) && out_ready) begin
            dz  <= 1'b0;
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_div_operand_sequencer.sv
// Scoreboard bench for div_operand_sequencer with a behavioural divide-core model
// and a signed-arithmetic reference computed from the operand values.
module tb_div_operand_sequencer;
   localparam int W = 32;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic [W-1:0]  div_a;
   logic [W-1:0]  div_b;
   logic          div_bgn;
   logic          div_stop;
   logic [W-1:0]  div_obus;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          dz;
   logic          ovf;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        ovf;
      logic        launch;
      logic [31:0] ma;
      logic [31:0] mb;
   } exp_t;

   exp_t exp_q[$];
   exp_t ab_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   int   bgn_cnt = 0;
   int   rdy_mode = 1;
   bit   long_lat = 1'b0;
   bit   prev_valid = 1'b0;

   div_operand_sequencer #(.W(W)) dut (
      .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .div_a(div_a), .div_b(div_b),
      .div_bgn(div_bgn), .div_stop(div_stop), .div_obus(div_obus),
      .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
      .remainder(remainder), .dz(dz), .ovf(ovf)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Truncating signed division done in 64-bit arithmetic.
   function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      int     ai;
      int     bi;
      longint la, lb, lq, lr, t;
      ai = a; bi = b; la = ai; lb = bi;
      e.dz = 1'b0; e.ovf = 1'b0; e.launch = 1'b0; e.ma = 32'h0; e.mb = 32'h0;
      if (b == 32'h0) begin
         e.dz = 1'b1; e.q = 32'hFFFF_FFFF; e.r = a;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.ovf = 1'b1; e.q = 32'h8000_0000; e.r = 32'h0;
      end else begin
         lq = la / lb; lr = la % lb;
         e.q = lq[31:0]; e.r = lr[31:0]; e.launch = 1'b1;
         t = (la < 0) ? -la : la; e.ma = t[31:0];
         t = (lb < 0) ? -lb : lb; e.mb = t[31:0];
      end
      return e;
   endfunction

   // Unsigned divide core: stop stays high one cycle past bgn, then remainder, then quotient.
   initial begin : core_model
      exp_t        ab;
      int          d;
      logic [31:0] ca, cb;
      div_stop = 1'b0;
      div_obus = 32'h0;
      forever begin
         @(posedge CLK); #1;
         if (div_bgn === 1'b1) begin
            ca = div_a; cb = div_b;
            if (ab_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL launch: div_bgn asserted, expected no launch");
            end else begin
               ab = ab_q.pop_front();
               chk("div_a", ca, ab.ma);
               chk("div_b", cb, ab.mb);
            end
            d = long_lat ? 12 : int'($urandom_range(1, 6));
            @(posedge CLK); #1;
            chk("bgn_width", {31'b0, div_bgn}, 32'h0);
            @(posedge CLK); #1;
            div_stop = 1'b0;
            div_obus = $urandom;
            repeat (d - 1) begin
               @(posedge CLK); #1;
               div_obus = $urandom;
            end
            @(posedge CLK); #1;
            div_stop = 1'b1;
            div_obus = (cb == 32'h0) ? 32'h0 : ca % cb;
            @(posedge CLK); #1;
            div_obus = (cb == 32'h0) ? 32'h0 : ca / cb;
         end
      end
   end

   // Consumer readiness, changed just after the edge so the monitor sees a settled value.
   initial begin : ready_drv
      out_ready = 1'b1;
      forever begin
         @(posedge CLK); #2;
         case (rdy_mode)
            1: out_ready = 1'b1;
            2: out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compares presented results against the scoreboard head every valid cycle.
   always @(negedge CLK) begin
      exp_t e;
      if (RESET) begin
         exp_q.delete();
         bgn_cnt = 0;
         prev_valid = 1'b0;
      end else begin
         if (div_bgn) bgn_cnt++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL spurious: out_valid=1 with no op outstanding, expected 0");
            end else begin
               e = exp_q[0];
               if (!prev_valid && !e.launch) chk("latency", 32'(cyc - accept_cyc), 32'd2);
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("dz", {31'b0, dz}, {31'b0, e.dz});
               chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
               chk("in_ready_busy", {31'b0, in_ready}, 32'h0);
               if (out_ready) begin
                  chk("bgn_count", 32'(bgn_cnt), {31'b0, e.launch});
                  void'(exp_q.pop_front());
                  bgn_cnt = 0;
               end
            end
         end
         prev_valid = out_valid;
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   t;
      e = ref_model(a, b);
      exp_q.push_back(e);
      if (e.launch) ab_q.push_back(e);
      @(negedge CLK);
      dividend = a; divisor = b; in_valid = 1'b1;
      t = 0;
      while (!in_ready) begin
         @(negedge CLK);
         t++;
         if (t > 500) begin
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
            $fatal(1);
         end
      end
      accept_cyc = cyc;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      dividend = $urandom; divisor = $urandom;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (exp_q.size() != 0) begin
         @(negedge CLK);
         t++;
         if (t > 500) begin
            $display("FAIL result_timeout: %0d results pending, expected 0", exp_q.size());
            $fatal(1);
         end
      end
      @(negedge CLK);
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      while (!out_valid) begin
         @(negedge CLK);
         t++;
         if (t > 500) begin
            $display("FAIL valid_timeout: out_valid stayed 0, expected 1");
            $fatal(1);
         end
      end
   endtask

   initial begin : stim
      logic [31:0] a, b;
      int t;
      RESET = 1'b1; in_valid = 1'b0; dividend = 32'h0; divisor = 32'h0;
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_div_bgn", {31'b0, div_bgn}, 32'h0);
      chk("rst_quotient", quotient, 32'h0);
      chk("rst_div_a", div_a, 32'h0);
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);
      chk("idle_in_ready", {31'b0, in_ready}, 32'h1);

      rdy_mode = 1;
      issue(32'd100, 32'd7);                       wait_done();
      issue(-32'sd100, 32'd7);                     wait_done();
      issue(32'd100, -32'sd7);                     wait_done();
      issue(-32'sd100, -32'sd7);                   wait_done();
      issue(32'd55, 32'd0);                        wait_done();
      issue(32'h8000_0000, 32'hFFFF_FFFF);         wait_done();
      issue(32'h8000_0000, 32'd2);                 wait_done();
      issue(32'h8000_0000, 32'd1);                 wait_done();

      rdy_mode = 2;
      issue(-32'sd100, 32'd7);
      wait_valid();
      repeat (10) @(negedge CLK);
      chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      rdy_mode = 1;
      wait_done();

      long_lat = 1'b1;
      issue(32'd1000, 32'd9);
      t = 0;
      while (!div_bgn) begin
         @(negedge CLK);
         t++;
         if (t > 50) begin
            $display("FAIL bgn_timeout: div_bgn stayed 0, expected 1");
            $fatal(1);
         end
      end
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h0);
      chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("mid_rst_div_bgn", {31'b0, div_bgn}, 32'h0);
      chk("mid_rst_div_a", div_a, 32'h0);
      chk("mid_rst_div_b", div_b, 32'h0);
      chk("mid_rst_quotient", quotient, 32'h0);
      chk("mid_rst_remainder", remainder, 32'h0);
      chk("mid_rst_flags", {30'b0, dz, ovf}, 32'h0);
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      long_lat = 1'b0;
      repeat (25) @(negedge CLK);
      chk("post_rst_no_valid", {31'b0, out_valid}, 32'h0);
      issue(-32'sd100, -32'sd7);                   wait_done();

      rdy_mode = 0;
      for (int i = 0; i < 60; i++) begin
         a = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         case ($urandom_range(0, 4))
            0: b = 32'h0;
            1: b = 32'($urandom_range(1, 20));
            2: b = 32'h0 - 32'($urandom_range(1, 20));
            3: b = $urandom;
            default: b = 32'hFFFF_FFFF;
         endcase
         issue(a, b);
         wait_done();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
